// File: rtl/ttl_latch_seq_pkg.sv
// Shared types and sizing helpers for the TTL latch sequencer.
package ttl_latch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_DRIVE   = 3'd4,
        ST_RELEASE = 3'd5
    } state_t;

    // One counter times both the LE pulse and the settle window, so size it for the longer one.
    function automatic int cnt_width(input int le_cycles, input int settle_cycles);
        int longest;
        longest = (le_cycles > settle_cycles) ? le_cycles : settle_cycles;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/ttl_rr_arbiter.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping.
module ttl_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any_req
);

    logic found;

    assign any_req = |req;

    always_comb begin
        int cand;
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = 0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = (int'(ptr) + off) % N_REQ;
            if (!found && req[cand]) begin
                found        = 1'b1;
                winner[cand] = 1'b1;
                winner_idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/ttl_latch_sequencer.sv
// Round-robin owner of a shared 74LS373 latch bank: loads the winner's byte,
// strobes LE, waits for the latch to settle, then drives _OE while the owner holds REQ.
module ttl_latch_sequencer
    import ttl_latch_seq_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int WIDTH         = 8,
    parameter int LE_CYCLES     = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       REQ,
    input  logic [N_REQ*WIDTH-1:0] DATA_IN,
    output logic [N_REQ-1:0]       GNT,
    output logic [N_REQ-1:0]       ACK,
    output logic [WIDTH-1:0]       LATCH_D,
    output logic                   LE,
    output logic                   _OE,
    output logic                   BUSY
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = cnt_width(LE_CYCLES, SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] LE_LOAD     = CNT_W'(LE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_REQ - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [N_REQ-1:0] gnt_next, ack_next;
    logic [WIDTH-1:0] latch_d_next;
    logic [N_REQ-1:0] arb_winner;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic             granted_req;

    ttl_rr_arbiter #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_arb (
        .req       (REQ),
        .ptr       (ptr),
        .winner    (arb_winner),
        .winner_idx(arb_idx),
        .any_req   (arb_any)
    );

    assign granted_req = |(REQ & GNT);

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        cnt_next     = cnt;
        gnt_next     = GNT;
        ack_next     = '0;
        latch_d_next = LATCH_D;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    state_next   = ST_SETUP;
                    gnt_next     = arb_winner;
                    latch_d_next = DATA_IN[arb_idx*WIDTH +: WIDTH];
                    ptr_next     = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
                end
            end
            ST_SETUP: begin
                state_next = ST_STROBE;
                cnt_next   = LE_LOAD;
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    state_next = ST_HOLD;
                    cnt_next   = SETTLE_LOAD;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                // Only the owner's REQ matters once the latch is loaded; a withdrawn owner gets no ACK.
                if (cnt == '0) begin
                    if (granted_req) begin
                        state_next = ST_DRIVE;
                        ack_next   = GNT;
                    end else begin
                        state_next = ST_RELEASE;
                        gnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_DRIVE: begin
                if (!granted_req) begin
                    state_next = ST_RELEASE;
                    gnt_next   = '0;
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    // Strobes are decoded from the next state so every output leaves a flop.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            GNT     <= '0;
            ACK     <= '0;
            LATCH_D <= '0;
            LE      <= 1'b0;
            _OE     <= 1'b1;
            BUSY    <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            cnt     <= cnt_next;
            GNT     <= gnt_next;
            ACK     <= ack_next;
            LATCH_D <= latch_d_next;
            LE      <= (state_next == ST_STROBE);
            _OE     <= (state_next != ST_DRIVE);
            BUSY    <= (state_next != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ttl_latch_sequencer.sv
// Bench for ttl_latch_sequencer: default-parameter instance plus an LE=3/settle=1 instance.
module tb_ttl_latch_sequencer;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LE1 = 1;
    localparam int ST1 = 2;
    localparam int LE2 = 3;
    localparam int ST2 = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, req2;
    logic [N*W-1:0] data, data2;
    logic [N-1:0]   gnt, ack, gnt2, ack2;
    logic [W-1:0]   latch_d, latch_d2;
    logic           le, oe_n, busy, le2, oe_n2, busy2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    logic [N-1:0] ack_prev  = '0;
    logic [N-1:0] ack2_prev = '0;

    always #5 clk = ~clk;

    ttl_latch_sequencer #(
        .N_REQ(N), .WIDTH(W), .LE_CYCLES(LE1), .SETTLE_CYCLES(ST1)
    ) u_dut (
        .CLK(clk), .RESET(rst), .REQ(req), .DATA_IN(data),
        .GNT(gnt), .ACK(ack), .LATCH_D(latch_d), .LE(le), ._OE(oe_n), .BUSY(busy)
    );

    ttl_latch_sequencer #(
        .N_REQ(N), .WIDTH(W), .LE_CYCLES(LE2), .SETTLE_CYCLES(ST2)
    ) u_dut2 (
        .CLK(clk), .RESET(rst), .REQ(req2), .DATA_IN(data2),
        .GNT(gnt2), .ACK(ack2), .LATCH_D(latch_d2), .LE(le2), ._OE(oe_n2), .BUSY(busy2)
    );

    // Invariants on both instances plus scoreboard pop on every ACK of the default instance.
    always @(negedge clk) begin : monitor
        exp_t         e;
        logic [N-1:0] oh;
        checks++;
        if ($countones(gnt) > 1 || (le === 1'b1 && oe_n === 1'b0) ||
            (ack & ~gnt) != '0 || (ack & ack_prev) != '0) begin
            errors++;
            $display("FAIL invariant_dut1: gnt=%b ack=%b le=%b oe_n=%b prev_ack=%b", gnt, ack, le, oe_n, ack_prev);
        end
        checks++;
        if ($countones(gnt2) > 1 || (le2 === 1'b1 && oe_n2 === 1'b0) ||
            (ack2 & ~gnt2) != '0 || (ack2 & ack2_prev) != '0) begin
            errors++;
            $display("FAIL invariant_dut2: gnt=%b ack=%b le=%b oe_n=%b prev_ack=%b", gnt2, ack2, le2, oe_n2, ack2_prev);
        end
        ack_prev  = ack;
        ack2_prev = ack2;
        if (ack !== '0) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got ack=%b, required no ack", ack);
            end else begin
                e = sb_q.pop_front();
                oh = '0;
                oh[e.idx] = 1'b1;
                if (ack !== oh || gnt !== oh || latch_d !== e.data || oe_n !== 1'b0) begin
                    errors++;
                    $display("FAIL sb_ack: got ack=%b gnt=%b latch_d=%h oe_n=%b, required ack=gnt=%b latch_d=%h oe_n=0",
                             ack, gnt, latch_d, oe_n, oh, e.data);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; req = '0; data = '0; req2 = '0; data2 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (gnt !== '0 || ack !== '0 || le !== 1'b0 || oe_n !== 1'b1 || latch_d !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: gnt=%b ack=%b le=%b oe_n=%b latch_d=%h busy=%b, required 0 0 0 1 00 0",
                     gnt, ack, le, oe_n, latch_d, busy);
        end
        rst = 1'b0;
        data[1*W +: W] = 8'h3C;
        req = 4'b0010;
        sb_q.push_back('{idx: 1, data: 8'h3C});
        for (int i = 0; i < 20 && oe_n !== 1'b0; i++) @(negedge clk);
        checks++;
        if (oe_n !== 1'b0) begin
            errors++;
            $display("FAIL reset_reach_drive: oe_n=%b, required 0 within 20 cycles", oe_n);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (oe_n !== 1'b1 || le !== 1'b0 || gnt !== '0 || ack !== '0) begin
            errors++;
            $display("FAIL reset_async: oe_n=%b le=%b gnt=%b ack=%b, required 1 0 0 0", oe_n, le, gnt, ack);
        end
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || gnt !== '0 || latch_d !== '0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b gnt=%b latch_d=%h, required 0 0 00", busy, gnt, latch_d);
        end
        req = 4'b1111;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL reset_ptr: gnt=%b, required 0001", gnt);
        end
        req = '0;
        for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_drain: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_single();
        logic exp_le, exp_oe;
        data = '0;
        data[7:0] = 8'hA5;
        req = 4'b0001;
        sb_q.push_back('{idx: 0, data: 8'hA5});
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp_le = (k >= 2 && k <= 1 + LE1);
            exp_oe = !(k >= 2 + LE1 + ST1);
            checks++;
            if (le !== exp_le || oe_n !== exp_oe) begin
                errors++;
                $display("FAIL single_le_oe: cycle %0d le=%b oe_n=%b, required le=%b oe_n=%b", k, le, oe_n, exp_le, exp_oe);
            end
            if (k == 1) begin
                checks++;
                if (gnt !== 4'b0001 || latch_d !== 8'hA5) begin
                    errors++;
                    $display("FAIL single_grant: gnt=%b latch_d=%h, required 0001 a5", gnt, latch_d);
                end
            end
            if (k == 2) data[7:0] = 8'hFF;
        end
        req = '0;
        @(negedge clk);
        checks++;
        if (oe_n !== 1'b1 || gnt !== '0) begin
            errors++;
            $display("FAIL single_release: oe_n=%b gnt=%b, required 1 0000", oe_n, gnt);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || latch_d !== 8'hA5) begin
            errors++;
            $display("FAIL single_idle: busy=%b latch_d=%h, required 0 a5", busy, latch_d);
        end
    endtask

    task automatic test_round_robin();
        int           hi_cycles;
        int           g;
        logic [N-1:0] exp_g;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) data[i*W +: W] = 8'(16 + i);
        for (int n = 0; n < 5; n++) sb_q.push_back('{idx: n % N, data: 8'(16 + (n % N))});
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            g = n % N;
            hi_cycles = 0;
            for (int i = 0; i < 30 && ack === '0; i++) begin
                if (oe_n === 1'b1) hi_cycles++;
                @(negedge clk);
            end
            exp_g = '0;
            exp_g[g] = 1'b1;
            checks++;
            if (ack !== exp_g) begin
                errors++;
                $display("FAIL rr_order: grant %0d ack=%b, required %b", n, ack, exp_g);
            end
            if (n > 0) begin
                checks++;
                if (hi_cycles < 1) begin
                    errors++;
                    $display("FAIL rr_gap: grant %0d oe_n high cycles=%0d, required >=1", n, hi_cycles);
                end
            end
            @(negedge clk);
            req[g] = 1'b0;
            @(negedge clk);
            req[g] = 1'b1;
        end
        req = '0;
        for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rr_drain: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_early_withdraw();
        data[2*W +: W] = 8'h5A;
        req = 4'b0100;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 2) begin
                checks++;
                if (le !== 1'b1) begin
                    errors++;
                    $display("FAIL ew_strobe: le=%b, required 1", le);
                end
                req = '0;
            end
            checks++;
            if (oe_n !== 1'b1 || ack !== '0) begin
                errors++;
                $display("FAIL ew_no_drive: cycle %0d oe_n=%b ack=%b, required 1 0000", k, oe_n, ack);
            end
            if (k == 3) begin
                checks++;
                if (le !== 1'b0 || gnt !== 4'b0100 || latch_d !== 8'h5A) begin
                    errors++;
                    $display("FAIL ew_hold: le=%b gnt=%b latch_d=%h, required 0 0100 5a", le, gnt, latch_d);
                end
            end
            if (k == 5) begin
                checks++;
                if (gnt !== '0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL ew_release: gnt=%b busy=%b, required 0000 1", gnt, busy);
                end
            end
            if (k == 6) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL ew_idle: busy=%b, required 0", busy);
                end
            end
        end
    endtask

    task automatic test_param_sweep();
        logic exp_le, exp_ack;
        data2 = '0;
        data2[7:0] = 8'hC3;
        req2 = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_le  = (k >= 2 && k <= 1 + LE2);
            exp_ack = (k == 2 + LE2 + ST2);
            checks++;
            if (le2 !== exp_le) begin
                errors++;
                $display("FAIL sweep_le: cycle %0d le=%b, required %b", k, le2, exp_le);
            end
            checks++;
            if ((ack2 === 4'b0001) !== exp_ack || (exp_ack && (latch_d2 !== 8'hC3 || oe_n2 !== 1'b0))) begin
                errors++;
                $display("FAIL sweep_ack: cycle %0d ack=%b latch_d=%h oe_n=%b, required ack_pulse=%b latch_d=c3",
                         k, ack2, latch_d2, oe_n2, exp_ack);
            end
        end
        req2 = '0;
        for (int i = 0; i < 20 && busy2 !== 1'b0; i++) @(negedge clk);
        checks++;
        if (busy2 !== 1'b0 || oe_n2 !== 1'b1) begin
            errors++;
            $display("FAIL sweep_drain: busy=%b oe_n=%b, required 0 1", busy2, oe_n2);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_early_withdraw();
        test_param_sweep();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected acks outstanding, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
